// File: rtl/risc_ifetch_buf_if.sv
// Fetch-buffer bus bundle: program-memory port, length-decoder hook, instruction output, redirect.
// Latency: none. This file only groups wires.
// Backpressure: out_valid/out_ready on the instruction side; the memory side allows a single outstanding request.
interface risc_ifetch_buf_if #(
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int MAX_ISIZE = 4
);
    localparam int LEN_W = (MAX_ISIZE > 1) ? $clog2(MAX_ISIZE) : 1;
    localparam int IMM_W = (MAX_ISIZE > 1) ? (MAX_ISIZE - 1) * WORD_W : WORD_W;

    // program memory read port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [WORD_W-1:0] mem_data;

    // external length decoder
    logic [WORD_W-1:0] len_op;
    logic [LEN_W-1:0]  len_in;

    // instruction output
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_op;
    logic [IMM_W-1:0]  out_imm;
    logic [ADDR_W-1:0] out_pc;

    // redirect
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;

    // fetch-buffer side
    modport master (
        output mem_req, mem_addr, len_op, out_valid, out_op, out_imm, out_pc,
        input  mem_valid, mem_data, len_in, out_ready, pc_load, pc_target
    );

    // memory / decoder / consumer side
    modport slave (
        input  mem_req, mem_addr, len_op, out_valid, out_op, out_imm, out_pc,
        output mem_valid, mem_data, len_in, out_ready, pc_load, pc_target
    );
endinterface

// File: rtl/risc_ifetch_buf.sv
// Instruction prefetch buffer: byte FIFO fed by program memory, emits whole variable-length instructions.
// Latency: a pushed byte is visible on the next cycle; a redirect at T fetches at T+1.
// Backpressure: out_ready stalls pops; fetching stops when the FIFO is full or a request is outstanding.
module risc_ifetch_buf #(
    parameter int          WORD_W    = 8,
    parameter int          ADDR_W    = 16,
    parameter int          MAX_ISIZE = 4,
    parameter int          DEPTH     = 8,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    risc_ifetch_buf_if.master    bus
);
    localparam int LEN_W = (MAX_ISIZE > 1) ? $clog2(MAX_ISIZE) : 1;
    localparam int IMM_W = (MAX_ISIZE > 1) ? (MAX_ISIZE - 1) * WORD_W : WORD_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WORD_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  len_p1;
    logic [ADDR_W-1:0] fa;
    logic [ADDR_W-1:0] hp;
    logic              os;
    logic              dr;
    logic              issue;
    logic              push;
    logic              pop;
    logic              inst_vld;
    logic [WORD_W-1:0] head;
    logic [IMM_W-1:0]  imm;

    // Control decode: redirect suppresses issue, push and pop in its cycle.
    // Issue is also held off during reset so no request leaks while rst is high.
    always_comb begin
        len_p1   = CNT_W'(bus.len_in) + CNT_W'(1);
        inst_vld = (count >= len_p1);
        issue    = !rst && !bus.pc_load && !os && (count < FULL);
        push     = bus.mem_valid && os && !dr && !bus.pc_load;
        pop      = inst_vld && bus.out_ready && !bus.pc_load;
    end

    // Instruction assembly from the FIFO head; bytes past the length, or not yet fetched, read as zero.
    always_comb begin
        head = (count != '0) ? fifo_mem[rd_ptr] : '0;
        imm  = '0;
        for (int k = 0; k < MAX_ISIZE - 1; k++) begin
            if ((CNT_W'(k) < CNT_W'(bus.len_in)) && (CNT_W'(k + 1) < count)) begin
                imm[k*WORD_W +: WORD_W] = fifo_mem[rd_ptr + PTR_W'(k + 1)];
            end
        end
    end

    assign bus.mem_req   = issue;
    assign bus.mem_addr  = fa;
    assign bus.len_op    = head;
    assign bus.out_op    = head;
    assign bus.out_imm   = imm;
    assign bus.out_valid = inst_vld;
    assign bus.out_pc    = hp;

    // Fetch/head state: redirect flushes and retargets; otherwise issue, response and pop bookkeeping.
    // A redirect with a request still in flight marks it stale (dr) so its data is dropped on arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa     <= ADDR_W'(RESET_PC);
            hp     <= ADDR_W'(RESET_PC);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            os     <= 1'b0;
            dr     <= 1'b0;
        end else if (bus.pc_load) begin
            fa     <= bus.pc_target;
            hp     <= bus.pc_target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (os && bus.mem_valid) begin
                os <= 1'b0;
                dr <= 1'b0;
            end else if (os) begin
                dr <= 1'b1;
            end
        end else begin
            if (issue) begin
                fa <= fa + ADDR_W'(1);
                os <= 1'b1;
            end
            if (os && bus.mem_valid) begin
                os <= 1'b0;
                dr <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(len_p1);
                hp     <= hp + ADDR_W'(len_p1);
            end
            count <= count + CNT_W'(push) - (pop ? len_p1 : '0);
        end
    end

    // FIFO storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_data;
        end
    end
endmodule

// File: tb/tb_risc_ifetch_buf.sv
// Directed bench for risc_ifetch_buf with a latency-programmable program memory and length table.
// Latency: memory latency is set per scenario.
// Backpressure: out_ready is driven per scenario.
module tb_risc_ifetch_buf;
    logic clk;
    logic rst;

    risc_ifetch_buf_if #(.WORD_W(8), .ADDR_W(16), .MAX_ISIZE(4)) ifc ();

    risc_ifetch_buf #(
        .WORD_W(8), .ADDR_W(16), .MAX_ISIZE(4), .DEPTH(8), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.master)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  pmem [65536];
    logic [1:0]  len_tab [256];
    int          mem_lat = 1;
    int          cyc = 0;
    bit          pend = 0;
    int          remain = 0;
    logic [15:0] paddr = '0;
    logic [15:0] req_addr_q [$];
    int          req_cyc_q [$];
    logic [15:0] resp_addr_q [$];
    int          resp_cyc_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external length decoder
    assign ifc.len_in = len_tab[ifc.len_op];

    // program memory: sample at the edge, respond mem_lat cycles after the request
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ifc.mem_valid === 1'b1) begin
            resp_addr_q.push_back(paddr);
            resp_cyc_q.push_back(cyc);
        end
        if (ifc.mem_req === 1'b1) begin
            req_addr_q.push_back(ifc.mem_addr);
            req_cyc_q.push_back(cyc);
            pend   = 1'b1;
            remain = mem_lat;
            paddr  = ifc.mem_addr;
        end
        #1;
        ifc.mem_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            remain = remain - 1;
            if (remain == 0) begin
                ifc.mem_valid = 1'b1;
                ifc.mem_data  = pmem[paddr];
                pend          = 1'b0;
            end
        end
    end

    task automatic setup_mem();
        for (int i = 0; i < 65536; i++) pmem[i] = 8'(i) ^ 8'h3C;
        for (int i = 0; i < 256; i++) len_tab[i] = 2'd0;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1;
        ifc.out_ready = 1'b0;
        ifc.pc_load   = 1'b0;
        ifc.pc_target = '0;
        mem_lat = lat;
        repeat (3) @(negedge clk);
        req_addr_q.delete();
        req_cyc_q.delete();
        resp_addr_q.delete();
        resp_cyc_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (ifc.out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ifc.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b expected 1", name, ifc.out_valid);
        end
    endtask

    task automatic pop_one();
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.out_ready = 1'b0;
        ifc.pc_load   = 1'b0;
        ifc.pc_target = '0;
        setup_mem();
        repeat (2) @(negedge clk);
        checks += 7;
        if (ifc.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", ifc.mem_req); end
        if (ifc.mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got %h exp 0000", ifc.mem_addr); end
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", ifc.out_valid); end
        if (ifc.out_op !== 8'h00) begin errors++; $display("FAIL rst_out_op got %h exp 00", ifc.out_op); end
        if (ifc.out_imm !== 24'h0) begin errors++; $display("FAIL rst_out_imm got %h exp 000000", ifc.out_imm); end
        if (ifc.out_pc !== 16'h0000) begin errors++; $display("FAIL rst_out_pc got %h exp 0000", ifc.out_pc); end
        if (ifc.len_op !== 8'h00) begin errors++; $display("FAIL rst_len_op got %h exp 00", ifc.len_op); end
    endtask

    task automatic test_single_bytes();
        logic [7:0]  exp_op [3];
        setup_mem();
        pmem[0] = 8'h10; pmem[1] = 8'h20; pmem[2] = 8'h30;
        exp_op[0] = 8'h10; exp_op[1] = 8'h20; exp_op[2] = 8'h30;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            wait_out("seq_valid");
            checks += 3;
            if (ifc.out_op !== exp_op[i]) begin errors++; $display("FAIL seq_op[%0d] got %h exp %h", i, ifc.out_op, exp_op[i]); end
            if (ifc.out_pc !== 16'(i)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, ifc.out_pc, 16'(i)); end
            if (ifc.out_imm !== 24'h0) begin errors++; $display("FAIL seq_imm[%0d] got %h exp 000000", i, ifc.out_imm); end
            pop_one();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_addr_q.size() <= i || req_addr_q[i] !== 16'(i)) begin
                errors++;
                $display("FAIL seq_req_addr[%0d] got %h exp %h", i, (req_addr_q.size() > i) ? req_addr_q[i] : 16'hxxxx, 16'(i));
            end
        end
    endtask

    task automatic test_three_byte();
        bit early = 0;
        int n = 0;
        setup_mem();
        pmem[0] = 8'hD0; pmem[1] = 8'hAA; pmem[2] = 8'hBB; pmem[3] = 8'h11;
        len_tab[8'hD0] = 2'd2;
        do_reset(1);
        while (ifc.out_valid !== 1'b1 && n < 60) begin
            if (resp_addr_q.size() >= 3) early = 1;
            @(negedge clk);
            n++;
        end
        checks += 5;
        if (early) begin errors++; $display("FAIL three_valid_late out_valid=0 with 3 bytes pushed exp 1"); end
        if (resp_addr_q.size() != 3) begin errors++; $display("FAIL three_count got %0d bytes at first valid exp 3", resp_addr_q.size()); end
        if (ifc.out_op !== 8'hD0) begin errors++; $display("FAIL three_op got %h exp d0", ifc.out_op); end
        if (ifc.out_imm !== 24'h00BBAA) begin errors++; $display("FAIL three_imm got %h exp 00bbaa", ifc.out_imm); end
        if (ifc.out_pc !== 16'h0000) begin errors++; $display("FAIL three_pc got %h exp 0000", ifc.out_pc); end
        pop_one();
        wait_out("three_next_valid");
        checks += 3;
        if (ifc.out_pc !== 16'h0003) begin errors++; $display("FAIL three_next_pc got %h exp 0003", ifc.out_pc); end
        if (ifc.out_op !== 8'h11) begin errors++; $display("FAIL three_next_op got %h exp 11", ifc.out_op); end
        if (ifc.out_imm !== 24'h0) begin errors++; $display("FAIL three_next_imm got %h exp 000000", ifc.out_imm); end
    endtask

    task automatic test_full();
        setup_mem();
        do_reset(1);
        repeat (40) @(negedge clk);
        checks += 3;
        if (req_addr_q.size() != 8) begin errors++; $display("FAIL full_req_count got %0d exp 8", req_addr_q.size()); end
        if (ifc.mem_req !== 1'b0) begin errors++; $display("FAIL full_mem_req got %b exp 0", ifc.mem_req); end
        if (ifc.out_op !== 8'h3C) begin errors++; $display("FAIL full_op got %h exp 3c", ifc.out_op); end
        pop_one();
        repeat (20) @(negedge clk);
        checks += 3;
        if (req_addr_q.size() != 9) begin errors++; $display("FAIL full_refetch_count got %0d exp 9", req_addr_q.size()); end
        if (req_addr_q.size() < 9 || req_addr_q[8] !== 16'h0008) begin errors++; $display("FAIL full_refetch_addr exp 0008 (count %0d)", req_addr_q.size()); end
        if (ifc.out_pc !== 16'h0001) begin errors++; $display("FAIL full_pc got %h exp 0001", ifc.out_pc); end
    endtask

    task automatic test_redirect_stale();
        int n = 0;
        setup_mem();
        do_reset(3);
        while (!(ifc.mem_req === 1'b1 && ifc.mem_addr === 16'h0005) && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ifc.mem_addr !== 16'h0005) begin errors++; $display("FAIL stale_setup mem_addr got %h exp 0005", ifc.mem_addr); end
        @(negedge clk);
        ifc.pc_target = 16'h0100;
        ifc.pc_load   = 1'b1;
        #1;
        checks++;
        if (ifc.mem_req !== 1'b0) begin errors++; $display("FAIL stale_redirect_req got %b exp 0", ifc.mem_req); end
        @(negedge clk);
        ifc.pc_load = 1'b0;
        wait_out("stale_valid");
        checks += 4;
        if (ifc.out_pc !== 16'h0100) begin errors++; $display("FAIL stale_pc got %h exp 0100", ifc.out_pc); end
        if (ifc.out_op !== 8'h3C) begin errors++; $display("FAIL stale_op got %h exp 3c", ifc.out_op); end
        if (req_addr_q.size() < 7 || req_addr_q[6] !== 16'h0100) begin errors++; $display("FAIL stale_next_addr exp 0100 (reqs %0d)", req_addr_q.size()); end
        if (req_cyc_q.size() < 7 || resp_cyc_q.size() < 6 || req_cyc_q[6] <= resp_cyc_q[5]) begin
            errors++;
            $display("FAIL stale_order new request not after stale response (reqs %0d resps %0d)", req_cyc_q.size(), resp_cyc_q.size());
        end
    endtask

    task automatic test_redirect_handshake();
        setup_mem();
        do_reset(1);
        wait_out("hs_first_valid");
        ifc.pc_target = 16'h0200;
        ifc.pc_load   = 1'b1;
        ifc.out_ready = 1'b1;
        #1;
        checks++;
        if (ifc.mem_req !== 1'b0) begin errors++; $display("FAIL hs_redirect_req got %b exp 0", ifc.mem_req); end
        @(negedge clk);
        ifc.pc_load   = 1'b0;
        ifc.out_ready = 1'b0;
        checks += 3;
        if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL hs_empty out_valid got %b exp 0", ifc.out_valid); end
        if (ifc.out_pc !== 16'h0200) begin errors++; $display("FAIL hs_pc got %h exp 0200", ifc.out_pc); end
        if (ifc.len_op !== 8'h00) begin errors++; $display("FAIL hs_len_op got %h exp 00", ifc.len_op); end
        wait_out("hs_target_valid");
        checks += 2;
        if (ifc.out_op !== 8'h3C) begin errors++; $display("FAIL hs_target_op got %h exp 3c", ifc.out_op); end
        if (ifc.out_pc !== 16'h0200) begin errors++; $display("FAIL hs_target_pc got %h exp 0200", ifc.out_pc); end
    endtask

    task automatic test_wrap();
        setup_mem();
        pmem[16'hFFFF] = 8'h81; pmem[0] = 8'h42; pmem[1] = 8'h83; pmem[2] = 8'h44;
        len_tab[8'h81] = 2'd1;
        len_tab[8'h83] = 2'd1;
        do_reset(1);
        ifc.pc_target = 16'hFFFF;
        ifc.pc_load   = 1'b1;
        @(negedge clk);
        ifc.pc_load = 1'b0;
        wait_out("wrap_valid0");
        checks += 3;
        if (ifc.out_op !== 8'h81) begin errors++; $display("FAIL wrap_op0 got %h exp 81", ifc.out_op); end
        if (ifc.out_imm !== 24'h000042) begin errors++; $display("FAIL wrap_imm0 got %h exp 000042", ifc.out_imm); end
        if (ifc.out_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc0 got %h exp ffff", ifc.out_pc); end
        pop_one();
        wait_out("wrap_valid1");
        checks += 5;
        if (ifc.out_op !== 8'h83) begin errors++; $display("FAIL wrap_op1 got %h exp 83", ifc.out_op); end
        if (ifc.out_imm !== 24'h000044) begin errors++; $display("FAIL wrap_imm1 got %h exp 000044", ifc.out_imm); end
        if (ifc.out_pc !== 16'h0001) begin errors++; $display("FAIL wrap_pc1 got %h exp 0001", ifc.out_pc); end
        if (req_addr_q.size() < 1 || req_addr_q[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 exp ffff (reqs %0d)", req_addr_q.size()); end
        if (req_addr_q.size() < 2 || req_addr_q[1] !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 exp 0000 (reqs %0d)", req_addr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_bytes();
        test_three_byte();
        test_full();
        test_redirect_stale();
        test_redirect_handshake();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/risc_ifetch_buf.md
# risc_ifetch_buf

Parametrised instruction-fetch buffer for the risc8 family cores. It sits between the byte-wide program memory port and the control decoder. It prefetches program bytes into a circular byte FIFO and presents one whole variable-length instruction per handshake: an opcode byte plus up to MAX_ISIZE-1 immediate bytes. It supports PC redirect (jump, branch, call, ret, interrupt entry) with in-flight fetch cancellation.

## Interface
Parameters:
- WORD_W, 8: bits per program byte/word.
- ADDR_W, 16: program address width.
- MAX_ISIZE, 4: maximum instruction length in words; must be ≥ 1.
- DEPTH, 8: FIFO depth in words; must be a power of 2 and ≥ MAX_ISIZE.
- RESET_PC, 0: fetch and output PC after reset.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- mem_req, out, 1: single-cycle read request pulse.
- mem_addr, out, ADDR_W: address for mem_req.
- mem_valid, in, 1: read data valid. Arrives ≥ 1 cycle after mem_req, in order.
- mem_data, in, WORD_W: read data, qualified by mem_valid.
- len_op, out, WORD_W: current head byte, passed to the external length decoder.
- len_in, in, $clog2(MAX_ISIZE) (min 1): instruction length minus 1 for len_op. Combinational return.
- out_valid, out, 1: whole instruction available.
- out_ready, in, 1: consumer accepts.
- out_op, out, WORD_W: opcode byte.
- out_imm, out, (MAX_ISIZE-1)*WORD_W: immediate bytes. Byte k (the k+1-th instruction byte) is at [k*WORD_W +: WORD_W]. Bytes beyond the instruction length are zero.
- out_pc, out, ADDR_W: address of out_op.
- pc_load, in, 1: redirect request.
- pc_target, in, ADDR_W: redirect address.

## Operation
- Internal state:
  - fetch address fa
  - head pc hp
  - FIFO read/write pointers with an explicit count (0..DEPTH)
  - outstanding flag os
  - drop flag dr
- Fetch issue:
  - Asserts mem_req with mem_addr=fa when os=0 and count < DEPTH.
  - Sets os and increments fa in the same edge.
  - At most one request is outstanding.
  - fa wraps from 2^ADDR_W-1 to 0.
- Response:
  - mem_valid with dr=0: pushes mem_data and clears os.
  - mem_valid with dr=1: data is discarded and both dr and os clear.
  - mem_valid with os=0 is ignored.
- Output:
  - out_valid = (count ≥ len_in+1).
  - len_op = out_op = FIFO head byte when count ≥ 1, else 0.
  - out_imm is assembled from the next len_in FIFO entries; the remaining entries are zero.
  - out_pc = hp.
- Pop:
  - On out_valid && out_ready && !pc_load, pops len_in+1 bytes.
  - hp advances by len_in+1, modulo 2^ADDR_W.
- Simultaneous push and pop in one cycle: count changes by +1-(len_in+1).
- Redirect (pc_load=1) has priority over everything:
  - count:=0, pointers reset, fa:=hp:=pc_target.
  - Any handshake in that cycle is void.
  - If os=1 and mem_valid is not present this cycle, dr:=1.
  - If os=1 and mem_valid is present this cycle, the data is dropped and os clears.
  - No mem_req is issued in the redirect cycle.
- Redirect while dr=1: retarget only. dr stays set until the stale response returns.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC.
  - out_valid=0, out_op=0, out_imm=0, out_pc=RESET_PC, len_op=0.
  - count=0, os=0, dr=0.
- First request is issued the first cycle after rst deasserts.
- Redirect at cycle T:
  - mem_req to pc_target at T+1, provided there is no stale outstanding request.
  - With a 1-cycle memory, the byte is pushed at the T+2 edge.
  - A 1-word instruction becomes out_valid in T+3.
- Steady-state throughput with a 1-cycle memory: one byte per 2 cycles (single outstanding request).
- out_valid, out_op, out_imm and out_pc are combinational from registered state and len_in. There is no combinational path from out_ready to out_valid.
- Reset asserted mid-fetch returns all state to reset values immediately. A late mem_valid after reset release with os=0 is ignored.

## Test plan
- Reset release with program bytes 0x10,0x20,0x30 at 0..2 and len_in=0 for all:
  - mem_req addr 0,1,2 in order.
  - out_valid with out_op=0x10, out_pc=0, out_imm=0.
  - Then 0x20 at pc 1, then 0x30 at pc 2.
- 3-byte instruction (len_in=2 for opcode 0xD0) followed by bytes 0xAA,0xBB:
  - out_valid stays low until count=3.
  - Then out_op=0xD0, out_imm=0x00BBAA, out_pc advances by 3.
- out_ready=0 with DEPTH=8:
  - Exactly 8 bytes are fetched, then mem_req stays low.
  - One 1-word pop re-enables exactly one fetch.
- pc_load to 0x0100 while a request to 0x0005 is outstanding, memory latency 3:
  - Stale data is dropped.
  - Next mem_req addr=0x0100 occurs only after the stale mem_valid.
  - First out_pc=0x0100.
- pc_load and an out_valid&&out_ready handshake in the same cycle:
  - No pop.
  - FIFO empty next cycle.
  - out_pc=target.
- fa=0xFFFF with ADDR_W=16 and 2-byte instructions: mem_addr goes 0xFFFF then 0x0000, and out_pc wraps the same way.
